// File: rtl/calab_axi_pkg.sv
// Shared definitions for the SRAM-like to AXI3 bridge: AXI IDs,
// FSM state encodings, SRAM size codes and fixed AXI attributes.
package calab_axi_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'd0;
    localparam logic [2:0] AXI_PROT_NONE   = 3'd0;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_AR   = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_SEND = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    // SRAM size code (byte/half/word) to AXI AxSIZE encoding
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/bridge_rd_ch.sv
// Read side of the bridge: arbitrates fetch vs. data loads onto the AR
// channel, keeps one outstanding flag per AXI ID, and routes R beats
// back to the owning master by rid[0].
module bridge_rd_ch
    import calab_axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_inst_req,
    input  logic [1:0]        i_inst_size,
    input  logic [ADDR_W-1:0] i_inst_addr,
    input  logic              i_inst_block,
    input  logic              i_data_rd_req,
    input  logic [1:0]        i_data_size,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic              i_wr_busy,
    output logic              o_inst_addr_ok,
    output logic              o_data_addr_ok,
    output logic              o_inst_data_ok,
    output logic              o_data_data_ok,
    output logic              o_data_rd_busy,
    output logic [3:0]        o_arid,
    output logic [ADDR_W-1:0] o_araddr,
    output logic [2:0]        o_arsize,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic              i_rid_lsb,
    input  logic              i_rvalid
);

    rd_state_e         r_state;
    rd_state_e         w_next_state;
    logic              r_inst_out;
    logic              r_data_out;
    logic [3:0]        r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [2:0]        r_arsize;
    logic              w_can_grant;
    logic              w_data_grant;
    logic              w_inst_grant;
    logic              w_inst_beat;
    logic              w_data_beat;

    // Arbitration (data load over fetch) and next read state; a new grant may overlap the AR handshake
    always_comb begin
        w_next_state = r_state;
        w_can_grant  = (r_state == RD_IDLE) || i_arready;
        w_data_grant = w_can_grant && i_data_rd_req && !r_data_out && !i_wr_busy;
        w_inst_grant = w_can_grant && !w_data_grant && i_inst_req && !r_inst_out && !i_inst_block;
        w_inst_beat  = i_rvalid && (i_rid_lsb == ID_INST[0]) && r_inst_out;
        w_data_beat  = i_rvalid && (i_rid_lsb == ID_DATA[0]) && r_data_out;
        case (r_state)
            RD_IDLE: begin
                if (w_data_grant || w_inst_grant) begin
                    w_next_state = RD_AR;
                end
            end
            RD_AR: begin
                if (i_arready) begin
                    w_next_state = (w_data_grant || w_inst_grant) ? RD_AR : RD_IDLE;
                end
            end
            default: w_next_state = RD_IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winning request onto the AR channel registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_arid   <= ID_INST;
            r_araddr <= '0;
            r_arsize <= 3'd0;
        end else if (w_data_grant) begin
            r_arid   <= ID_DATA;
            r_araddr <= i_data_addr;
            r_arsize <= axi_size(i_data_size);
        end else if (w_inst_grant) begin
            r_arid   <= ID_INST;
            r_araddr <= i_inst_addr;
            r_arsize <= axi_size(i_inst_size);
        end
    end

    // Per-ID outstanding flags: set on grant, cleared by the matching R beat
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_inst_out <= 1'b0;
            r_data_out <= 1'b0;
        end else begin
            if (w_inst_grant) begin
                r_inst_out <= 1'b1;
            end else if (w_inst_beat) begin
                r_inst_out <= 1'b0;
            end
            if (w_data_grant) begin
                r_data_out <= 1'b1;
            end else if (w_data_beat) begin
                r_data_out <= 1'b0;
            end
        end
    end

    assign o_inst_addr_ok = w_inst_grant;
    assign o_data_addr_ok = w_data_grant;
    assign o_inst_data_ok = w_inst_beat;
    assign o_data_data_ok = w_data_beat;
    assign o_data_rd_busy = r_data_out;
    assign o_arid         = r_arid;
    assign o_araddr       = r_araddr;
    assign o_arsize       = r_arsize;
    assign o_arvalid      = (r_state == RD_AR);

endmodule

// File: rtl/sram_axi_bridge.sv
// Shares one AXI3 port between the instruction fetch and data SRAM-like
// masters. Reads go through bridge_rd_ch; the single-beat write FSM lives
// here. Optional macro BRIDGE_RAW_CHECK_EN holds back fetches that hit the
// word of a store still in flight.
module sram_axi_bridge
    import calab_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_inst_sram_req,
    input  logic              i_inst_sram_wr,
    input  logic [1:0]        i_inst_sram_size,
    input  logic [ADDR_W-1:0] i_inst_sram_addr,
    output logic              o_inst_sram_addr_ok,
    output logic              o_inst_sram_data_ok,
    output logic [DATA_W-1:0] o_inst_sram_rdata,
    input  logic              i_data_sram_req,
    input  logic              i_data_sram_wr,
    input  logic [1:0]        i_data_sram_size,
    input  logic [3:0]        i_data_sram_wstrb,
    input  logic [ADDR_W-1:0] i_data_sram_addr,
    input  logic [DATA_W-1:0] i_data_sram_wdata,
    output logic              o_data_sram_addr_ok,
    output logic              o_data_sram_data_ok,
    output logic [DATA_W-1:0] o_data_sram_rdata,
    output logic [3:0]        o_arid,
    output logic [ADDR_W-1:0] o_araddr,
    output logic [7:0]        o_arlen,
    output logic [2:0]        o_arsize,
    output logic [1:0]        o_arburst,
    output logic [1:0]        o_arlock,
    output logic [3:0]        o_arcache,
    output logic [2:0]        o_arprot,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [3:0]        i_rid,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rlast,
    input  logic              i_rvalid,
    output logic              o_rready,
    output logic [3:0]        o_awid,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic [7:0]        o_awlen,
    output logic [2:0]        o_awsize,
    output logic [1:0]        o_awburst,
    output logic [1:0]        o_awlock,
    output logic [3:0]        o_awcache,
    output logic [2:0]        o_awprot,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [3:0]        o_wid,
    output logic [DATA_W-1:0] o_wdata,
    output logic [3:0]        o_wstrb,
    output logic              o_wlast,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [3:0]        i_bid,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready
);

    wr_state_e         r_wr_state;
    wr_state_e         w_wr_next;
    logic              r_aw_pend;
    logic              r_w_pend;
    logic [ADDR_W-1:0] r_awaddr;
    logic [2:0]        r_awsize;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_wdata;
    logic              w_wr_grant;
    logic              w_b_ok;
    logic              w_wr_busy;
    logic              w_inst_block;
    logic              w_data_rd_busy;
    logic              w_rd_data_addr_ok;
    logic              w_rd_data_data_ok;
    logic              w_unused;

    assign w_wr_busy = (r_wr_state != WR_IDLE);

`ifdef BRIDGE_RAW_CHECK_EN
    assign w_inst_block = w_wr_busy && (i_inst_sram_addr[ADDR_W-1:2] == r_awaddr[ADDR_W-1:2]);
`else
    assign w_inst_block = 1'b0;
`endif

    bridge_rd_ch #(
        .ADDR_W(ADDR_W)
    ) u_rd_ch (
        .clk            (clk),
        .resetn         (resetn),
        .i_inst_req     (i_inst_sram_req),
        .i_inst_size    (i_inst_sram_size),
        .i_inst_addr    (i_inst_sram_addr),
        .i_inst_block   (w_inst_block),
        .i_data_rd_req  (i_data_sram_req && !i_data_sram_wr),
        .i_data_size    (i_data_sram_size),
        .i_data_addr    (i_data_sram_addr),
        .i_wr_busy      (w_wr_busy),
        .o_inst_addr_ok (o_inst_sram_addr_ok),
        .o_data_addr_ok (w_rd_data_addr_ok),
        .o_inst_data_ok (o_inst_sram_data_ok),
        .o_data_data_ok (w_rd_data_data_ok),
        .o_data_rd_busy (w_data_rd_busy),
        .o_arid         (o_arid),
        .o_araddr       (o_araddr),
        .o_arsize       (o_arsize),
        .o_arvalid      (o_arvalid),
        .i_arready      (i_arready),
        .i_rid_lsb      (i_rid[0]),
        .i_rvalid       (i_rvalid)
    );

    // Write FSM next state; a store waits for any outstanding data load (which also covers one still on AR)
    always_comb begin
        w_wr_next  = r_wr_state;
        w_wr_grant = 1'b0;
        w_b_ok     = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (i_data_sram_req && i_data_sram_wr && !w_data_rd_busy) begin
                    w_wr_grant = 1'b1;
                    w_wr_next  = WR_SEND;
                end
            end
            WR_SEND: begin
                if ((!r_aw_pend || i_awready) && (!r_w_pend || i_wready)) begin
                    w_wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (i_bvalid) begin
                    w_b_ok    = 1'b1;
                    w_wr_next = WR_IDLE;
                end
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
        end
    end

    // Latch the store on grant; AW and W valids then drop independently on their own handshakes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_awaddr  <= '0;
            r_awsize  <= 3'd0;
            r_wstrb   <= 4'd0;
            r_wdata   <= '0;
        end else if (w_wr_grant) begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
            r_awaddr  <= i_data_sram_addr;
            r_awsize  <= axi_size(i_data_sram_size);
            r_wstrb   <= i_data_sram_wstrb;
            r_wdata   <= i_data_sram_wdata;
        end else begin
            r_aw_pend <= r_aw_pend && !i_awready;
            r_w_pend  <= r_w_pend && !i_wready;
        end
    end

    assign o_data_sram_addr_ok = w_rd_data_addr_ok || w_wr_grant;
    assign o_data_sram_data_ok = w_rd_data_data_ok || w_b_ok;
    assign o_inst_sram_rdata   = i_rdata;
    assign o_data_sram_rdata   = i_rdata;

    assign o_arlen   = AXI_LEN_SINGLE;
    assign o_arburst = AXI_BURST_INCR;
    assign o_arlock  = AXI_LOCK_NORMAL;
    assign o_arcache = AXI_CACHE_NONE;
    assign o_arprot  = AXI_PROT_NONE;
    assign o_rready  = 1'b1;

    assign o_awid    = ID_DATA;
    assign o_awaddr  = r_awaddr;
    assign o_awlen   = AXI_LEN_SINGLE;
    assign o_awsize  = r_awsize;
    assign o_awburst = AXI_BURST_INCR;
    assign o_awlock  = AXI_LOCK_NORMAL;
    assign o_awcache = AXI_CACHE_NONE;
    assign o_awprot  = AXI_PROT_NONE;
    assign o_awvalid = r_aw_pend;

    assign o_wid     = ID_DATA;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;
    assign o_wlast   = 1'b1;
    assign o_wvalid  = r_w_pend;
    assign o_bready  = 1'b1;

    assign w_unused = ^{i_inst_sram_wr, i_rid[3:1], i_rresp, i_rlast, i_bid, i_bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a transaction-level model of
// outstanding requests that is checked against the DUT every cycle.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        instReq, instWr;
    logic [1:0]  instSize;
    logic [31:0] instAddr;
    logic        instAddrOk, instDataOk;
    logic [31:0] instRdata;
    logic        dataReq, dataWr;
    logic [1:0]  dataSize;
    logic [3:0]  dataWstrb;
    logic [31:0] dataAddr, dataWdata;
    logic        dataAddrOk, dataDataOk;
    logic [31:0] dataRdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int totalChecks = 0;
    int badChecks   = 0;

    sram_axi_bridge dut (
        .clk                 (clk),
        .resetn              (resetn),
        .i_inst_sram_req     (instReq),
        .i_inst_sram_wr      (instWr),
        .i_inst_sram_size    (instSize),
        .i_inst_sram_addr    (instAddr),
        .o_inst_sram_addr_ok (instAddrOk),
        .o_inst_sram_data_ok (instDataOk),
        .o_inst_sram_rdata   (instRdata),
        .i_data_sram_req     (dataReq),
        .i_data_sram_wr      (dataWr),
        .i_data_sram_size    (dataSize),
        .i_data_sram_wstrb   (dataWstrb),
        .i_data_sram_addr    (dataAddr),
        .i_data_sram_wdata   (dataWdata),
        .o_data_sram_addr_ok (dataAddrOk),
        .o_data_sram_data_ok (dataDataOk),
        .o_data_sram_rdata   (dataRdata),
        .o_arid              (arid),
        .o_araddr            (araddr),
        .o_arlen             (arlen),
        .o_arsize            (arsize),
        .o_arburst           (arburst),
        .o_arlock            (arlock),
        .o_arcache           (arcache),
        .o_arprot            (arprot),
        .o_arvalid           (arvalid),
        .i_arready           (arready),
        .i_rid               (rid),
        .i_rdata             (rdata),
        .i_rresp             (rresp),
        .i_rlast             (rlast),
        .i_rvalid            (rvalid),
        .o_rready            (rready),
        .o_awid              (awid),
        .o_awaddr            (awaddr),
        .o_awlen             (awlen),
        .o_awsize            (awsize),
        .o_awburst           (awburst),
        .o_awlock            (awlock),
        .o_awcache           (awcache),
        .o_awprot            (awprot),
        .o_awvalid           (awvalid),
        .i_awready           (awready),
        .o_wid               (wid),
        .o_wdata             (wdata),
        .o_wstrb             (wstrb),
        .o_wlast             (wlast),
        .o_wvalid            (wvalid),
        .i_wready            (wready),
        .i_bid               (bid),
        .i_bresp             (bresp),
        .i_bvalid            (bvalid),
        .o_bready            (bready)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to the drive point just after the next rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleOutputs();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        instReq = 0; instWr = 0; instSize = 2'd2; instAddr = '0;
        dataReq = 0; dataWr = 0; dataSize = 2'd2; dataWstrb = 4'h0;
        dataAddr = '0; dataWdata = '0;
        arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 4'd1; bresp = '0; bvalid = 0;
    endtask

    // Transaction-level model: pending AR requests, outstanding reads per master, one pending store
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } arReq_t;

    arReq_t      arQ[$];
    arReq_t      arHead;
    int          instPend = 0;
    int          dataRdPend = 0;
    bit          wrActive = 0, awDone = 0, wDone = 0;
    logic [31:0] wrAddr, wrData;
    logic [3:0]  wrStrb;
    logic [2:0]  wrSize;
    bit          prevArStall = 0;
    logic [31:0] prevAraddr;
    logic [3:0]  prevArid;
    logic        expInstOk, expDataOk;

    // Compare DUT against the model on every falling edge while out of reset
    always @(negedge clk) begin
        if (!resetn) begin
            arQ.delete();
            instPend = 0; dataRdPend = 0;
            wrActive = 0; awDone = 0; wDone = 0;
            prevArStall = 0;
        end else begin
            checkOutput("model_arvalid", arvalid, arQ.size() > 0);
            if (prevArStall) begin
                checkOutput("ar_hold_addr", araddr, prevAraddr);
                checkOutput("ar_hold_id", arid, prevArid);
            end
            if (arvalid && arready) begin
                if (arQ.size() == 0) begin
                    checkOutput("ar_unexpected", 1, 0);
                end else begin
                    arHead = arQ.pop_front();
                    checkOutput("model_arid", arid, arHead.id);
                    checkOutput("model_araddr", araddr, arHead.addr);
                    checkOutput("model_arsize", arsize, arHead.size);
                end
            end
            prevArStall = arvalid && !arready;
            prevAraddr  = araddr;
            prevArid    = arid;

            expInstOk = rvalid && (rid[0] == 1'b0) && (instPend > 0);
            checkOutput("model_inst_data_ok", instDataOk, expInstOk);
            if (instDataOk && expInstOk) begin
                checkOutput("model_inst_rdata", instRdata, rdata);
                instPend--;
            end
            expDataOk = (rvalid && (rid[0] == 1'b1) && (dataRdPend > 0)) ||
                        (bvalid && wrActive && awDone && wDone);
            checkOutput("model_data_data_ok", dataDataOk, expDataOk);
            if (dataDataOk && rvalid && rid[0] && (dataRdPend > 0)) begin
                checkOutput("model_data_rdata", dataRdata, rdata);
                dataRdPend--;
            end else if (dataDataOk && wrActive) begin
                wrActive = 0;
            end

            checkOutput("model_awvalid", awvalid, wrActive && !awDone);
            checkOutput("model_wvalid", wvalid, wrActive && !wDone);
            if (awvalid && awready && wrActive && !awDone) begin
                checkOutput("model_awaddr", awaddr, wrAddr);
                checkOutput("model_awsize", awsize, wrSize);
                awDone = 1;
            end
            if (wvalid && wready && wrActive && !wDone) begin
                checkOutput("model_wdata", wdata, wrData);
                checkOutput("model_wstrb", wstrb, wrStrb);
                wDone = 1;
            end

            checkOutput("addr_ok_exclusive", instAddrOk && dataAddrOk, 0);
            if (instAddrOk) begin
                checkOutput("inst_addr_ok_req", instReq, 1);
                arQ.push_back(arReq_t'({4'd0, instAddr, {1'b0, instSize}}));
                instPend++;
            end
            if (dataAddrOk) begin
                checkOutput("data_addr_ok_req", dataReq, 1);
                checkOutput("data_single_outstanding", (dataRdPend > 0) || wrActive, 0);
                if (dataWr) begin
                    wrActive = 1; awDone = 0; wDone = 0;
                    wrAddr = dataAddr; wrData = dataWdata;
                    wrStrb = dataWstrb; wrSize = {1'b0, dataSize};
                end else begin
                    arQ.push_back(arReq_t'({4'd1, dataAddr, {1'b0, dataSize}}));
                    dataRdPend++;
                end
            end
        end
    end

    // Safety net so the run can never hang
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int grantK;
    int expGrantK;

    // Directed scenarios
    initial begin
        idleInputs();
        resetn = 0;
        repeat (3) @(posedge clk);
        sampleOutputs();
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_wvalid", wvalid, 0);
        checkOutput("rst_rready", rready, 1);
        checkOutput("rst_bready", bready, 1);
        checkOutput("rst_inst_data_ok", instDataOk, 0);
        checkOutput("rst_data_data_ok", dataDataOk, 0);
        checkOutput("const_arlen", arlen, 0);
        checkOutput("const_arburst", arburst, 1);
        checkOutput("const_awid", awid, 1);
        checkOutput("const_awburst", awburst, 1);
        checkOutput("const_wlast", wlast, 1);
        applyStimulus();
        resetn = 1;

        $display("[TB] fetch and load together, out-of-order R");
        applyStimulus();
        instReq = 1; instAddr = 32'h1c00_0000; instSize = 2'd2;
        dataReq = 1; dataWr = 0; dataAddr = 32'h0000_1000; dataSize = 2'd2;
        sampleOutputs();
        checkOutput("t1_data_addr_ok", dataAddrOk, 1);
        checkOutput("t1_inst_addr_ok", instAddrOk, 0);
        applyStimulus();
        dataReq = 0;
        sampleOutputs();
        checkOutput("t1_arvalid", arvalid, 1);
        checkOutput("t1_arid_data", arid, 1);
        checkOutput("t1_araddr_data", araddr, 32'h0000_1000);
        checkOutput("t1_arsize", arsize, 3'd2);
        checkOutput("t1_inst_wait", instAddrOk, 0);
        applyStimulus();
        arready = 1;
        sampleOutputs();
        checkOutput("t1_inst_grant_on_hs", instAddrOk, 1);
        applyStimulus();
        arready = 0; instReq = 0;
        sampleOutputs();
        checkOutput("t1_arid_inst", arid, 0);
        checkOutput("t1_araddr_inst", araddr, 32'h1c00_0000);
        applyStimulus();
        arready = 1;
        sampleOutputs();
        applyStimulus();
        arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h1111_1111;
        sampleOutputs();
        checkOutput("t1_inst_data_ok", instDataOk, 1);
        checkOutput("t1_inst_rdata", instRdata, 32'h1111_1111);
        checkOutput("t1_data_not_ok", dataDataOk, 0);
        checkOutput("t1_arvalid_low", arvalid, 0);
        applyStimulus();
        rid = 4'd1; rdata = 32'h2222_2222;
        sampleOutputs();
        checkOutput("t1_data_data_ok", dataDataOk, 1);
        checkOutput("t1_data_rdata", dataRdata, 32'h2222_2222);
        checkOutput("t1_inst_not_ok", instDataOk, 0);
        applyStimulus();
        rvalid = 0;
        sampleOutputs();
        checkOutput("t1_quiet_inst", instDataOk, 0);
        checkOutput("t1_quiet_data", dataDataOk, 0);

        $display("[TB] store with AW ahead of W");
        applyStimulus();
        dataReq = 1; dataWr = 1; dataAddr = 32'h0000_2000; dataSize = 2'd2;
        dataWstrb = 4'hF; dataWdata = 32'hdead_beef;
        sampleOutputs();
        checkOutput("t2_addr_ok", dataAddrOk, 1);
        applyStimulus();
        dataReq = 0; awready = 1;
        sampleOutputs();
        checkOutput("t2_awvalid", awvalid, 1);
        checkOutput("t2_wvalid", wvalid, 1);
        checkOutput("t2_awaddr", awaddr, 32'h0000_2000);
        checkOutput("t2_wdata", wdata, 32'hdead_beef);
        checkOutput("t2_wstrb", wstrb, 4'hF);
        applyStimulus();
        awready = 0;
        sampleOutputs();
        checkOutput("t2_aw_dropped", awvalid, 0);
        checkOutput("t2_w_held", wvalid, 1);
        applyStimulus();
        wready = 1;
        sampleOutputs();
        checkOutput("t2_w_still", wvalid, 1);
        checkOutput("t2_no_early_ok", dataDataOk, 0);
        applyStimulus();
        wready = 0;
        sampleOutputs();
        checkOutput("t2_w_dropped", wvalid, 0);
        checkOutput("t2_wait_b", dataDataOk, 0);
        applyStimulus();
        bvalid = 1;
        sampleOutputs();
        checkOutput("t2_b_ok", dataDataOk, 1);
        applyStimulus();
        bvalid = 0;
        sampleOutputs();
        checkOutput("t2_b_once", dataDataOk, 0);

        $display("[TB] store then load, then AR stall");
        applyStimulus();
        dataReq = 1; dataWr = 1; dataAddr = 32'h0000_3000; dataWdata = 32'hcafe_f00d; dataWstrb = 4'h3;
        sampleOutputs();
        checkOutput("t3_store_ok", dataAddrOk, 1);
        applyStimulus();
        dataWr = 0; dataAddr = 32'h0000_3004; awready = 1; wready = 1;
        sampleOutputs();
        checkOutput("t3_load_held_a", dataAddrOk, 0);
        applyStimulus();
        awready = 0; wready = 0;
        sampleOutputs();
        checkOutput("t3_load_held_b", dataAddrOk, 0);
        applyStimulus();
        bvalid = 1;
        sampleOutputs();
        checkOutput("t3_b_ok", dataDataOk, 1);
        checkOutput("t3_load_held_c", dataAddrOk, 0);
        applyStimulus();
        bvalid = 0;
        sampleOutputs();
        checkOutput("t3_load_granted", dataAddrOk, 1);
        applyStimulus();
        dataAddr = 32'h0000_4000;
        for (int i = 0; i < 5; i++) begin
            sampleOutputs();
            checkOutput("t4_arvalid_stall", arvalid, 1);
            checkOutput("t4_araddr_stall", araddr, 32'h0000_3004);
            checkOutput("t4_no_second_ok", dataAddrOk, 0);
            applyStimulus();
        end
        dataReq = 0; arready = 1;
        sampleOutputs();
        checkOutput("t4_arvalid_hs", arvalid, 1);
        applyStimulus();
        arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h3333_3333;
        sampleOutputs();
        checkOutput("t4_load_ok", dataDataOk, 1);
        checkOutput("t4_load_rdata", dataRdata, 32'h3333_3333);
        applyStimulus();
        rvalid = 0;

        $display("[TB] reset during store");
        applyStimulus();
        dataReq = 1; dataWr = 1; dataAddr = 32'h0000_5000; dataWdata = 32'h0123_4567; dataWstrb = 4'hF;
        sampleOutputs();
        checkOutput("t5_store_ok", dataAddrOk, 1);
        applyStimulus();
        dataReq = 0;
        sampleOutputs();
        checkOutput("t5_awvalid_pre", awvalid, 1);
        #1;
        resetn = 0;
        applyStimulus();
        sampleOutputs();
        checkOutput("t5_awvalid_rst", awvalid, 0);
        checkOutput("t5_wvalid_rst", wvalid, 0);
        checkOutput("t5_arvalid_rst", arvalid, 0);
        applyStimulus();
        resetn = 1; instReq = 1; instAddr = 32'h1c00_0010;
        sampleOutputs();
        checkOutput("t5_fetch_ok", instAddrOk, 1);
        applyStimulus();
        instReq = 0; arready = 1;
        sampleOutputs();
        checkOutput("t5_fetch_araddr", araddr, 32'h1c00_0010);
        checkOutput("t5_fetch_arid", arid, 0);
        applyStimulus();
        arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h4444_4444;
        sampleOutputs();
        checkOutput("t5_fetch_data_ok", instDataOk, 1);
        checkOutput("t5_fetch_rdata", instRdata, 32'h4444_4444);
        applyStimulus();
        rvalid = 0;

        $display("[TB] fetch to the word of a pending store");
`ifdef BRIDGE_RAW_CHECK_EN
        expGrantK = 3;
`else
        expGrantK = 0;
`endif
        applyStimulus();
        dataReq = 1; dataWr = 1; dataAddr = 32'h1c00_0004; dataWdata = 32'h0bad_f00d; dataWstrb = 4'hF;
        sampleOutputs();
        checkOutput("t6_store_ok", dataAddrOk, 1);
        grantK = -1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus();
            dataReq = 0;
            awready = (k == 0);
            wready  = (k == 0);
            bvalid  = (k == 2);
            instReq = (grantK < 0);
            instAddr = 32'h1c00_0004;
            sampleOutputs();
            if (instAddrOk && grantK < 0) grantK = k;
        end
        checkOutput("t6_fetch_grant_cycle", grantK, expGrantK);
        applyStimulus();
        instReq = 0; arready = 1;
        sampleOutputs();
        checkOutput("t6_araddr", araddr, 32'h1c00_0004);
        applyStimulus();
        arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h5555_5555;
        sampleOutputs();
        checkOutput("t6_fetch_data_ok", instDataOk, 1);
        applyStimulus();
        rvalid = 0;
        repeat (3) applyStimulus();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Arbiter and protocol converter that shares the single AXI3 memory port between the IF-stage instruction master and the EX-stage data master.
- Each master uses the pipeline's SRAM-like interface (req / addr_ok / data_ok).
- The bridge sequences the AR, R, AW, W and B channels.
- Sits between the CPU core top and the SoC AXI interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32 in this design)

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
inst_sram_req / inst_sram_wr  in  1/1  fetch request; wr is always 0 and ignored
inst_sram_size / inst_sram_addr  in  2/32  fetch size, fetch address
inst_sram_addr_ok / inst_sram_data_ok  out  1/1  address accepted; read data returned
inst_sram_rdata  out  32  fetch data
data_sram_req / data_sram_wr  in  1/1  data request; 1 = store
data_sram_size / data_sram_wstrb  in  2/4  size code (0 byte, 1 half, 2 word); byte strobes
data_sram_addr / data_sram_wdata  in  32/32  data address, store data
data_sram_addr_ok / data_sram_data_ok  out  1/1  data handshake
data_sram_rdata  out  32  load data
arid / araddr / arsize / arvalid  out  4/32/3/1  AR channel
arready  in  1  AR ready
arlen, arburst, arlock, arcache, arprot  out  8/2/2/4/3  constants 0, 1, 0, 0, 0
rid / rdata / rresp / rlast / rvalid  in  4/32/2/1/1  R channel
rready  out  1  R ready
awid, awaddr, awsize, awlen, awburst, awlock, awcache, awprot, awvalid  out  4/32/3/8/2/2/4/3/1  AW channel; awid=1, awlen=0, awburst=1, other constants 0
awready  in  1  AW ready
wid, wdata, wstrb, wlast, wvalid  out  4/32/4/1/1  W channel; wid=1, wlast=1
wready  in  1  W ready
bid / bresp / bvalid  in  4/2/1  B channel
bready  out  1  B ready

Behaviour:
- Reset: arvalid, awvalid, wvalid, both addr_ok and both data_ok = 0; rready = bready = 1; all FSMs return to idle. Reset mid-transaction abandons it.
- Read FSM RD_IDLE -> RD_AR -> RD_IDLE; a separate per-ID outstanding flag is held until the matching R beat.
- RD_IDLE arbitration:
  - Data read (req & ~wr) wins over fetch when both are present.
  - A master is eligible only if its outstanding flag is clear.
  - The data master is additionally blocked while a write is outstanding.
  - The winner's addr_ok = 1 combinationally in this cycle.
  - Latch arid (0 = inst, 1 = data), araddr, arsize = {1'b0, size}; go to RD_AR.
- RD_AR: arvalid = 1, held stable until arready; then back to RD_IDLE.
  - A new grant is allowed in the same cycle as the arready handshake.
- R channel: on rvalid, the master selected by rid[0] gets data_ok = 1 and rdata = rdata for one cycle; its outstanding flag clears. rresp is ignored.
- Write FSM WR_IDLE -> WR_SEND -> WR_RESP -> WR_IDLE.
  - WR_IDLE: data req & wr, no data read outstanding, read FSM not holding data in RD_AR -> data_sram_addr_ok = 1; latch addr, size, wstrb, wdata.
  - WR_SEND: awvalid and wvalid raised together. Each drops independently on its own ready handshake. Leave when both are done; handshakes in the same cycle are legal.
  - WR_RESP: on bvalid, data_sram_data_ok = 1, return to WR_IDLE.
- Data master ordering: at most one data transaction (read or write) outstanding, so loads and stores complete in program order.
- addr_ok goes only to a master whose req = 1. It is never asserted to both masters in one cycle. data_ok is never asserted to the same master twice for one request.
- Simultaneous rvalid (data) and bvalid is impossible, because data is serialized.
- Simultaneous inst R beat and data B response: both data_ok outputs assert in the same cycle.

Optional Feature:
BRIDGE_RAW_CHECK_EN
- Defined: fetch grant is withheld while a write is outstanding and inst_sram_addr[31:2] == latched awaddr[31:2]. Covers self-modifying code.
- Undefined: no cross-master address comparison; fetches may pass pending stores.

Decomposition:
- Shared package (calab_axi_pkg): AXI ID constants (ID_INST = 0, ID_DATA = 1), read/write FSM state encodings, SRAM size codes, fixed AXI attribute constants.
- One natural sub-module: bridge_rd_ch, holding the read arbiter, read FSM and outstanding flags. Write FSM and top glue stay in sram_axi_bridge.

Test Plan:
1. Fetch and data load request in the same cycle, addr 0x1c000000 / 0x00001000 -> data granted first (arid = 1); inst granted after arready; data_ok returned per rid, including out-of-order R beats.
2. Store word 0x00002000, wdata 0xdeadbeef, wstrb 0xF; awready asserts 2 cycles before wready -> awvalid drops first, wvalid held; data_ok only on bvalid.
3. Store followed immediately by a load -> load addr_ok withheld until B response, then AR issued.
4. arready held low for 5 cycles -> arvalid and araddr stable throughout; no second addr_ok.
5. resetn low during WR_SEND -> all valids 0 next cycle; a fresh fetch after reset completes normally.
6. With BRIDGE_RAW_CHECK_EN: store to 0x1c000004 outstanding, fetch 0x1c000004 -> fetch addr_ok held 0 until bvalid. Without the macro, fetch is granted immediately.
